// File: rtl/data_mem_ctrl.sv
// Single-port word memory with byte strobes, self-clearing on reset release,
// and a fixed-latency (1 or 2 cycle) in-order response pipeline.
module data_mem_ctrl #(
   parameter int ABITS  = 32,
   parameter int DBITS  = 32,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [DBITS/8-1:0] req_be,
   input  logic [ABITS-1:0]   req_addr,
   input  logic [DBITS-1:0]   req_wdata,
   output logic               rsp_valid,
   output logic [DBITS-1:0]   rsp_rdata,
   output logic               rsp_err
);

   localparam int NBYTES = DBITS / 8;
   localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_IDLE = 1'b1;

   localparam logic [ABITS:0] DEPTH_EXT = (ABITS + 1)'(DEPTH);
   localparam logic [IW-1:0]  LAST_IDX  = IW'(DEPTH - 1);

   logic [DBITS-1:0] mem [DEPTH];

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] init_idx_q, init_idx_d;

   logic              accept;
   logic              in_range;
   logic [IW-1:0]     req_idx;

   logic              mem_we;
   logic [IW-1:0]     mem_idx;
   logic [NBYTES-1:0] mem_be;
   logic [DBITS-1:0]  mem_wdata;

   logic              rsp1_valid_q, rsp1_valid_d;
   logic              rsp1_err_q, rsp1_err_d;
   logic [DBITS-1:0]  rsp1_rdata_q, rsp1_rdata_d;

   assign req_ready = (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
   assign req_idx   = req_addr[IW-1:0];

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      if (state_q == ST_INIT) begin
         if (init_idx_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            init_idx_d = '0;
         end else begin
            init_idx_d = init_idx_q + 1'b1;
         end
      end
   end

   // INIT owns the storage port; afterwards only in-range accepted writes reach it.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = req_idx;
      mem_be    = req_be;
      mem_wdata = req_wdata;
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_idx   = init_idx_q;
         mem_be    = '1;
         mem_wdata = '0;
      end else if (accept && req_we && in_range) begin
         mem_we = 1'b1;
      end
   end

   always_comb begin
      rsp1_valid_d = accept;
      rsp1_err_d   = accept && !in_range;
      rsp1_rdata_d = '0;
      if (accept && !req_we && in_range) begin
         rsp1_rdata_d = mem[req_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (mem_be[b]) begin
               mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         rsp1_valid_q <= 1'b0;
         rsp1_err_q   <= 1'b0;
         rsp1_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_err_q   <= rsp1_err_d;
         rsp1_rdata_q <= rsp1_rdata_d;
      end
   end

   // Second stage only exists for RD_LAT=2; it simply delays the first by one cycle.
   generate
      if (RD_LAT == 2) begin : g_lat2
         logic             rsp2_valid_q, rsp2_valid_d;
         logic             rsp2_err_q, rsp2_err_d;
         logic [DBITS-1:0] rsp2_rdata_q, rsp2_rdata_d;

         always_comb begin
            rsp2_valid_d = rsp1_valid_q;
            rsp2_err_d   = rsp1_err_q;
            rsp2_rdata_d = rsp1_rdata_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rsp2_valid_q <= 1'b0;
               rsp2_err_q   <= 1'b0;
               rsp2_rdata_q <= '0;
            end else begin
               rsp2_valid_q <= rsp2_valid_d;
               rsp2_err_q   <= rsp2_err_d;
               rsp2_rdata_q <= rsp2_rdata_d;
            end
         end

         assign rsp_valid = rsp2_valid_q;
         assign rsp_err   = rsp2_err_q;
         assign rsp_rdata = rsp2_rdata_q;
      end else begin : g_lat1
         assign rsp_valid = rsp1_valid_q;
         assign rsp_err   = rsp1_err_q;
         assign rsp_rdata = rsp1_rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one RD_LAT=1 and one RD_LAT=2 instance
// share clock, reset and request inputs; each has its own response outputs.
module tb_data_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        reqValid;
   logic        reqWe;
   logic [3:0]  reqBe;
   logic [7:0]  reqAddr;
   logic [31:0] reqWdata;

   logic        ready1, rspValid1, rspErr1;
   logic [31:0] rspRdata1;
   logic        ready2, rspValid2, rspErr2;
   logic [31:0] rspRdata2;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int lowCount1;
   int lowCount2;

   data_mem_ctrl #(.ABITS(8), .DBITS(32), .DEPTH(16), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid), .req_ready(ready1), .req_we(reqWe),
      .req_be(reqBe), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid1), .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
   );

   data_mem_ctrl #(.ABITS(8), .DBITS(32), .DEPTH(16), .RD_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid), .req_ready(ready2), .req_we(reqWe),
      .req_be(reqBe), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid2), .rsp_rdata(rspRdata2), .rsp_err(rspErr2)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and on mismatch reports tag, observed and expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Presents one request for exactly one edge, returning 1 unit after that edge.
   task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [7:0] addr,
                                input logic [31:0] wdata);
      reqValid = 1'b1;
      reqWe    = we;
      reqBe    = be;
      reqAddr  = addr;
      reqWdata = wdata;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      reqWe    = 1'b0;
      reqBe    = 4'h0;
      reqAddr  = 8'h00;
      reqWdata = 32'h0;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Counts how many sample points each instance shows req_ready=0 after release.
   task automatic measureInit();
      lowCount1 = 0;
      lowCount2 = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (!ready1) lowCount1++;
         if (!ready2) lowCount2++;
         if (ready1 && ready2) break;
         stepCycle();
      end
   endtask

   // Directed sequence: reset, init, writes/reads, errors, latency-2, mid-run resets.
   initial begin
      rst_n    = 1'b0;
      reqValid = 1'b0;
      reqWe    = 1'b0;
      reqBe    = 4'h0;
      reqAddr  = 8'h00;
      reqWdata = 32'h0;
      repeat (3) stepCycle();

      checkOutput("reset_ready1", {31'b0, ready1}, 32'd0);
      checkOutput("reset_valid1", {31'b0, rspValid1}, 32'd0);
      checkOutput("reset_rdata1", rspRdata1, 32'h0);
      checkOutput("reset_err1", {31'b0, rspErr1}, 32'd0);
      checkOutput("reset_valid2", {31'b0, rspValid2}, 32'd0);

      rst_n = 1'b1;
      measureInit();
      checkOutput("init_low_cycles1", lowCount1, 32'd16);
      checkOutput("init_low_cycles2", lowCount2, 32'd16);
      checkOutput("init_ready1", {31'b0, ready1}, 32'd1);

      applyStimulus(1'b0, 4'h0, 8'h00, 32'h0);
      checkOutput("rd0_valid", {31'b0, rspValid1}, 32'd1);
      checkOutput("rd0_rdata", rspRdata1, 32'h0);
      checkOutput("rd0_err", {31'b0, rspErr1}, 32'd0);

      applyStimulus(1'b1, 4'hF, 8'h00, 32'h0000F123);
      checkOutput("wr0_valid", {31'b0, rspValid1}, 32'd1);
      checkOutput("wr0_rdata", rspRdata1, 32'h0);
      applyStimulus(1'b0, 4'h0, 8'h00, 32'h0);
      checkOutput("raw0_valid", {31'b0, rspValid1}, 32'd1);
      checkOutput("raw0_rdata", rspRdata1, 32'h0000F123);
      stepCycle();
      checkOutput("idle_valid", {31'b0, rspValid1}, 32'd0);
      checkOutput("idle_rdata", rspRdata1, 32'h0);

      applyStimulus(1'b1, 4'hF, 8'h05, 32'h11223344);
      applyStimulus(1'b1, 4'b0101, 8'h05, 32'hAABBCCDD);
      applyStimulus(1'b0, 4'h0, 8'h05, 32'h0);
      checkOutput("be_merge_rdata", rspRdata1, 32'h11BB33DD);

      applyStimulus(1'b1, 4'h0, 8'h05, 32'hFFFFFFFF);
      checkOutput("be0_valid", {31'b0, rspValid1}, 32'd1);
      checkOutput("be0_err", {31'b0, rspErr1}, 32'd0);
      applyStimulus(1'b0, 4'h0, 8'h05, 32'h0);
      checkOutput("be0_rdata", rspRdata1, 32'h11BB33DD);

      applyStimulus(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
      checkOutput("oor_wr_err", {31'b0, rspErr1}, 32'd1);
      checkOutput("oor_wr_rdata", rspRdata1, 32'h0);
      applyStimulus(1'b0, 4'h0, 8'h00, 32'h0);
      checkOutput("nowrap_rdata", rspRdata1, 32'h0000F123);
      checkOutput("nowrap_err", {31'b0, rspErr1}, 32'd0);
      applyStimulus(1'b0, 4'h0, 8'h10, 32'h0);
      checkOutput("oor_rd_rdata", rspRdata1, 32'h0);
      checkOutput("oor_rd_err", {31'b0, rspErr1}, 32'd1);
      applyStimulus(1'b0, 4'h0, 8'hFF, 32'h0);
      checkOutput("oor_top_err", {31'b0, rspErr1}, 32'd1);

      // Write-looking inputs without req_valid must not touch storage.
      reqWe    = 1'b1;
      reqBe    = 4'hF;
      reqAddr  = 8'h00;
      reqWdata = 32'hCAFEBABE;
      stepCycle();
      checkOutput("novalid_rsp", {31'b0, rspValid1}, 32'd0);
      applyStimulus(1'b0, 4'h0, 8'h00, 32'h0);
      checkOutput("novalid_rdata", rspRdata1, 32'h0000F123);
      stepCycle();

      applyStimulus(1'b1, 4'hF, 8'h03, 32'h00000007);
      checkOutput("lat2_wr_early", {31'b0, rspValid2}, 32'd0);
      applyStimulus(1'b0, 4'h0, 8'h03, 32'h0);
      checkOutput("lat2_wr_valid", {31'b0, rspValid2}, 32'd1);
      checkOutput("lat2_wr_rdata", rspRdata2, 32'h0);
      checkOutput("lat1_rd_rdata", rspRdata1, 32'h00000007);
      stepCycle();
      checkOutput("lat2_rd_valid", {31'b0, rspValid2}, 32'd1);
      checkOutput("lat2_rd_rdata", rspRdata2, 32'h00000007);
      checkOutput("lat2_rd_err", {31'b0, rspErr2}, 32'd0);
      stepCycle();
      checkOutput("lat2_drop_valid", {31'b0, rspValid2}, 32'd0);
      checkOutput("lat2_drop_rdata", rspRdata2, 32'h0);

      rst_n = 1'b0;
      stepCycle();
      rst_n = 1'b1;
      repeat (8) stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("midinit_ready", {31'b0, ready1}, 32'd0);
      stepCycle();
      rst_n = 1'b1;
      measureInit();
      checkOutput("reinit_low1", lowCount1, 32'd16);
      checkOutput("reinit_low2", lowCount2, 32'd16);

      applyStimulus(1'b0, 4'h0, 8'h00, 32'h0);
      rst_n = 1'b0;
      #1;
      checkOutput("discard_valid2", {31'b0, rspValid2}, 32'd0);
      stepCycle();
      checkOutput("discard_valid2b", {31'b0, rspValid2}, 32'd0);
      checkOutput("discard_valid1", {31'b0, rspValid1}, 32'd0);
      rst_n = 1'b1;
      checkOutput("discard_valid2c", {31'b0, rspValid2}, 32'd0);
      measureInit();
      checkOutput("rerun_low1", lowCount1, 32'd16);
      checkOutput("rerun_low2", lowCount2, 32'd16);

      applyStimulus(1'b0, 4'h0, 8'h05, 32'h0);
      checkOutput("cleared_rdata", rspRdata1, 32'h0);
      stepCycle();
      checkOutput("cleared_rdata2", rspRdata2, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 32, request address width in bits.
REQ-002 SHALL have parameter DBITS, default 32, data width in bits; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DBITS-wide words; valid range 2..2^ABITS.
REQ-004 SHALL have parameter RD_LAT, default 1, request-to-response latency in cycles; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block can accept a request.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_be  input  DBITS/8  byte write strobes; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have port req_addr  input  ABITS  word address.
REQ-012 SHALL have port req_wdata  input  DBITS  write data.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have port rsp_rdata  output  DBITS  read data; 0 for write responses.
REQ-015 SHALL have port rsp_err  output  1  response is for an out-of-range address; valid with rsp_valid.

Function
REQ-016 SHALL hold a DEPTH x DBITS storage array, single port, one access per cycle.
REQ-017 SHALL implement states INIT and IDLE; INIT after reset release, IDLE after initialisation.
REQ-018 In INIT, SHALL write 0 to one word per cycle, index 0 to DEPTH-1, and drive req_ready=0.
REQ-019 SHALL enter IDLE in the cycle after word DEPTH-1 is cleared; req_ready=1 from then on.
REQ-020 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-021 In IDLE, req_ready SHALL stay 1; no response backpressure exists.
REQ-022 Each accepted request SHALL produce exactly one response, with rsp_valid=1 exactly RD_LAT cycles after acceptance; responses in acceptance order.
REQ-023 For an accepted write with req_addr < DEPTH, SHALL update only the bytes whose req_be bit is 1 and leave the other bytes unchanged.
REQ-024 A write with req_be all 0 SHALL leave storage unchanged and still respond with rsp_err=0.
REQ-025 For an accepted read with req_addr < DEPTH, rsp_rdata SHALL equal the word contents after all previously accepted writes, including a write accepted in the immediately preceding cycle.
REQ-026 For req_addr >= DEPTH, SHALL suppress any write, return rsp_rdata=0, and set rsp_err=1; no address wrap-around.
REQ-027 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.
REQ-028 With RD_LAT=2, back-to-back requests SHALL be accepted every cycle; the second pipeline stage holds the response for exactly one cycle.
REQ-029 req_be, req_wdata and req_we SHALL be ignored when no request is accepted.

Reset
REQ-030 While rst_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=INIT, init index=0, response pipeline empty.
REQ-031 Asserting rst_n mid-INIT or mid-operation SHALL discard pending responses and restart INIT from index 0 after release.
REQ-032 Storage contents SHALL not be cleared asynchronously; clearing happens only through INIT.

Verification (DBITS=32, DEPTH=16, RD_LAT=1 unless stated)
REQ-033 Release rst_n -> req_ready=0 for 16 cycles, then 1; read addr 0x0 -> rsp_rdata=0x00000000, rsp_err=0.
REQ-034 Write 0x0000F123 to addr 0x0, be=4'b1111; next cycle read addr 0x0 -> one cycle later rsp_valid=1, rsp_rdata=0x0000F123.
REQ-035 Write 0x11223344 to addr 0x5, then 0xAABBCCDD with be=4'b0101; read addr 0x5 -> rsp_rdata=0x11BB33DD.
REQ-036 Write 0xDEADBEEF to addr 0x10 -> rsp_err=1; read addr 0x0 -> previous value unchanged; read addr 0x10 -> rsp_rdata=0, rsp_err=1.
REQ-037 RD_LAT=2: write 0x00000007 to addr 0x3 then read addr 0x3 on consecutive cycles -> two responses on consecutive cycles, the second 2 cycles after its request, carrying rdata 0x00000007.
REQ-038 Assert rst_n=0 during INIT at index 8 and again one cycle after accepting a read -> no rsp_valid from the discarded read; after release, req_ready=0 for 16 cycles again.
